// File: rtl/regfile_pkg.sv
// Shared constants and payload types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned CNT_W    = 6;

  // Write-back port payload.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_t;

  // True when the address targets a writable (non-zero) register.
  function automatic logic addr_nz(input logic [ADDR_W-1:0] addr);
    return addr != ADDR_W'(REG_ZERO);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard with pending-register counter.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   set_i / set_idx_i     issue marks register pending (index already non-zero checked)
//   clr_i / clr_idx_i     write-back clears pending (index already non-zero checked)
//   ra1_i / ra2_i         read addresses, status returned one cycle later
//   busy1_o / busy2_o     registered post-update busy status for ra1_i / ra2_i
//   pending_cnt_o         number of registers currently pending
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic              busy1_o,
  output logic              busy2_o,
  output logic [CNT_W-1:0]  pending_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy1_q, busy1_d;
  logic             busy2_q, busy2_d;
  logic             inc_c, dec_c;

  // Next busy vector: clear first, then set so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_idx_i] = 1'b0;
    if (set_i) busy_d[set_idx_i] = 1'b1;
  end

  // Count only real transitions; a set+clear on the same busy reg is a no-op.
  always_comb begin
    inc_c   = set_i && !busy_q[set_idx_i];
    dec_c   = clr_i && busy_q[clr_idx_i] && !(set_i && (set_idx_i == clr_idx_i));
    cnt_d   = cnt_q + CNT_W'(inc_c) - CNT_W'(dec_c);
    busy1_d = busy_d[ra1_i];
    busy2_d = busy_d[ra2_i];
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      busy1_q <= busy1_d;
      busy2_q <= busy2_d;
    end
  end

  assign busy1_o       = busy1_q;
  assign busy2_o       = busy2_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// 32x32 register file, two registered read ports with write-first bypass,
// one write-back port, and a pending-register scoreboard.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   ra1, ra2              read addresses
//   rd1, rd2              registered read data (1-cycle latency)
//   we, wa, wd            write-back port
//   issue_valid, issue_rd mark destination register pending
//   busy1, busy2          registered pending status aligned with rd1/rd2
//   pending_cnt           count of pending registers
module regfile_sb
  import regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_INIT = 32'h00003FFC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              busy1,
  output logic              busy2,
  output logic [CNT_W-1:0]  pending_cnt
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  wb_t               wb_c;
  logic              wr_en_c;
  logic              iss_en_c;

  assign wb_c     = '{we: we, wa: wa, wd: wd};
  assign wr_en_c  = wb_c.we && addr_nz(wb_c.wa);
  assign iss_en_c = issue_valid && addr_nz(issue_rd);

  // Read mux: r0 is hardwired, a same-edge write is forwarded.
  always_comb begin
    rd1_d = regs_q[ra1];
    rd2_d = regs_q[ra2];
    if (!addr_nz(ra1))                rd1_d = '0;
    else if (wr_en_c && wb_c.wa == ra1) rd1_d = wb_c.wd;
    if (!addr_nz(ra2))                rd2_d = '0;
    else if (wr_en_c && wb_c.wa == ra2) rd2_d = wb_c.wd;
  end

  // Register storage; r29 resets to the initial stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (wr_en_c) begin
      regs_q[wb_c.wa] <= wb_c.wd;
    end
  end

  // Read data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
    end
  end

  assign rd1 = rd1_q;
  assign rd2 = rd2_q;

  regfile_scoreboard u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .set_i         (iss_en_c),
    .set_idx_i     (issue_rd),
    .clr_i         (wr_en_c),
    .clr_idx_i     (wb_c.wa),
    .ra1_i         (ra1),
    .ra2_i         (ra2),
    .busy1_o       (busy1),
    .busy2_o       (busy2),
    .pending_cnt_o (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-style bench for regfile_sb: the driver pushes hand-computed
// expected outputs per edge; the monitor pops and compares on the next negedge.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, issue_rd;
  logic [31:0] rd1, rd2, wd;
  logic        we, issue_valid, busy1, busy2;
  logic [5:0]  pending_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        b1;
    logic        b2;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_sb #(.SP_INIT(32'h00003FFC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra1         (ra1),
    .ra2         (ra2),
    .rd1         (rd1),
    .rd2         (rd2),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy1       (busy1),
    .busy2       (busy2),
    .pending_cnt (pending_cnt)
  );

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, id, act, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle after a driven edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd1", e.id, rd1, e.rd1);
        chk("rd2", e.id, rd2, e.rd2);
        chk("busy1", e.id, 32'(busy1), 32'(e.b1));
        chk("busy2", e.id, 32'(busy2), 32'(e.b2));
        chk("pending_cnt", e.id, 32'(pending_cnt), 32'(e.cnt));
      end
    end
  end

  // Drive one edge and queue what must appear after it.
  task automatic step(input int id, input logic [4:0] a1, input logic [4:0] a2,
                      input logic w, input logic [4:0] wadr, input logic [31:0] wdat,
                      input logic iv, input logic [4:0] ird,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic eb1, input logic eb2, input logic [5:0] ecnt);
    exp_t e;
    ra1 = a1; ra2 = a2; we = w; wa = wadr; wd = wdat;
    issue_valid = iv; issue_rd = ird;
    @(posedge clk);
    e.id = id; e.rd1 = e1; e.rd2 = e2; e.b1 = eb1; e.b2 = eb2; e.cnt = ecnt;
    exp_q.push_back(e);
    #1;
    we = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    ra1 = '0; ra2 = '0; we = 1'b0; wa = '0; wd = '0;
    issue_valid = 1'b0; issue_rd = '0;
    repeat (3) @(negedge clk);
    chk("reset_rd1", 0, rd1, 32'h0);
    chk("reset_cnt", 0, 32'(pending_cnt), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    //    id  ra1 ra2 we wa  wd            iv  ird  rd1           rd2           b1 b2 cnt
    step(1,  29, 0,  0, 0,  32'h0,        0,  0,   32'h00003FFC, 32'h0,        0, 0, 0);
    step(2,  5,  29, 1, 5,  32'hDEADBEEF, 0,  0,   32'hDEADBEEF, 32'h00003FFC, 0, 0, 0);
    step(3,  0,  5,  1, 0,  32'h1,        0,  0,   32'h0,        32'hDEADBEEF, 0, 0, 0);
    step(4,  0,  0,  0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);
    step(5,  7,  8,  0, 0,  32'h0,        1,  7,   32'h0,        32'h0,        1, 0, 1);
    step(6,  7,  8,  0, 0,  32'h0,        1,  8,   32'h0,        32'h0,        1, 1, 2);
    step(7,  7,  8,  1, 7,  32'h1234,     0,  0,   32'h1234,     32'h0,        0, 1, 1);
    step(8,  9,  8,  0, 0,  32'h0,        1,  9,   32'h0,        32'h0,        1, 1, 2);
    step(9,  9,  8,  1, 9,  32'hCAFE,     1,  9,   32'hCAFE,     32'h0,        1, 1, 2);
    step(10, 0,  9,  0, 0,  32'h0,        1,  0,   32'h0,        32'hCAFE,     0, 1, 2);
    step(11, 7,  8,  1, 8,  32'h88,       1,  7,   32'h1234,     32'h88,       1, 0, 2);
    step(12, 7,  0,  0, 0,  32'h0,        1,  7,   32'h1234,     32'h0,        1, 0, 2);
    step(13, 5,  0,  1, 5,  32'h55,       0,  0,   32'h55,       32'h0,        0, 0, 2);
    step(14, 9,  7,  1, 9,  32'h99,       0,  0,   32'h99,       32'h1234,     0, 1, 1);
    step(15, 7,  9,  1, 7,  32'h77,       0,  0,   32'h77,       32'h99,       0, 0, 0);
    step(16, 3,  29, 1, 3,  32'h333,      1,  3,   32'h333,      32'h00003FFC, 1, 0, 1);

    // Mid-cycle reset with a write and an issue in flight.
    @(negedge clk); #1;
    we = 1'b1; wa = 5'd4; wd = 32'h4444; issue_valid = 1'b1; issue_rd = 5'd4;
    rst_n = 1'b0;
    #1;
    chk("async_rd1", 32, rd1, 32'h0);
    chk("async_rd2", 32, rd2, 32'h0);
    chk("async_busy1", 32, 32'(busy1), 32'h0);
    chk("async_cnt", 32, 32'(pending_cnt), 32'h0);
    @(posedge clk); #1;
    we = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    step(17, 3,  29, 0, 0,  32'h0,        0,  0,   32'h0,        32'h00003FFC, 0, 0, 0);
    step(18, 4,  5,  0, 0,  32'h0,        0,  0,   32'h0,        32'h0,        0, 0, 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
